// File: rtl/mtr_spd_sched_if.sv
// Command/status bundle between the speed scheduler and its controller.
// master drives enables and targets; slave (the scheduler) returns speeds and status.
interface mtr_spd_sched_if;
  logic               en;
  logic               brake_req;
  logic signed [10:0] tgt_lft;
  logic signed [10:0] tgt_rght;
  logic signed [10:0] lft_spd;
  logic signed [10:0] rght_spd;
  logic               at_tgt;
  logic               moving;
  logic [1:0]         state;

  modport master (
    output en, brake_req, tgt_lft, tgt_rght,
    input  lft_spd, rght_spd, at_tgt, moving, state
  );

  modport slave (
    input  en, brake_req, tgt_lft, tgt_rght,
    output lft_spd, rght_spd, at_tgt, moving, state
  );
endinterface

// File: rtl/mtr_spd_sched.sv
// Slew-limited left/right wheel speed scheduler with soft-start and controlled braking.
// Optional target deadband is enabled by defining MTR_DEADBAND_EN.
module mtr_spd_sched #(
  parameter int unsigned UPD_DIV   = 2048,
  parameter int unsigned RAMP_STEP = 8,
  parameter int unsigned BRK_STEP  = 32,
  parameter int unsigned SPD_MAX   = 1023,
  parameter int unsigned DEADBAND  = 16
) (
  input logic              clk,
  input logic              rst_n,
  mtr_spd_sched_if.slave   bus
);

  localparam int unsigned       CntW     = (UPD_DIV > 2) ? $clog2(UPD_DIV) : 1;
  localparam logic [CntW-1:0]   CntLast  = CntW'(UPD_DIV - 1);
  localparam logic signed [11:0] SpdMaxP = 12'(SPD_MAX);
  localparam logic signed [11:0] SpdMaxN = -SpdMaxP;
  localparam logic signed [11:0] RampStp = 12'(RAMP_STEP);
  localparam logic signed [11:0] BrkStp  = 12'(BRK_STEP);

  if (UPD_DIV < 2 || SPD_MAX < 1 || SPD_MAX > 1023 || DEADBAND > 1023) begin : g_param_err
    $error("mtr_spd_sched: parameter out of range");
  end

`ifdef MTR_DEADBAND_EN
  localparam logic signed [11:0] DbLim = 12'(DEADBAND);
`endif

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StBrake = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q;
  logic               tick;
  logic signed [10:0] lft_q, lft_d, rght_q, rght_d;
  logic               at_tgt_q, at_tgt_d;
  logic               moving_q, moving_d;
  logic signed [11:0] lft_cur, rght_cur;
  logic signed [11:0] cond_lft, cond_rght;

  // Sign-extend, clamp to +/-SPD_MAX and optionally apply the deadband.
  function automatic logic signed [11:0] cond_tgt(input logic signed [10:0] t);
    logic signed [11:0] x;
    x = {t[10], t};
    if (x > SpdMaxP) begin
      x = SpdMaxP;
    end else if (x < SpdMaxN) begin
      x = SpdMaxN;
    end
`ifdef MTR_DEADBAND_EN
    if ((x > -DbLim) && (x < DbLim)) begin
      x = '0;
    end
`endif
    return x;
  endfunction

  // One slew step toward goal; operands stay within +/-1023 so diff fits 12 bits.
  function automatic logic signed [10:0] ramp(input logic signed [11:0] cur,
                                              input logic signed [11:0] goal,
                                              input logic signed [11:0] step);
    logic signed [11:0] diff, mag, nxt;
    diff = goal - cur;
    mag  = diff[11] ? -diff : diff;
    if (mag <= step) begin
      nxt = goal;
    end else if (diff[11]) begin
      nxt = cur - step;
    end else begin
      nxt = cur + step;
    end
    return nxt[10:0];
  endfunction

  assign tick      = (cnt_q == CntLast);
  assign lft_cur   = {lft_q[10], lft_q};
  assign rght_cur  = {rght_q[10], rght_q};
  assign cond_lft  = cond_tgt(bus.tgt_lft);
  assign cond_rght = cond_tgt(bus.tgt_rght);

  // Update tick pacing runs in every state, aligned to the PWM period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    lft_d   = lft_q;
    rght_d  = rght_q;
    unique case (state_q)
      StIdle: begin
        lft_d  = '0;
        rght_d = '0;
        if (bus.en && !bus.brake_req) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (tick) begin
          lft_d  = ramp(lft_cur, cond_lft, RampStp);
          rght_d = ramp(rght_cur, cond_rght, RampStp);
        end
        if (!bus.en || bus.brake_req) begin
          state_d = StBrake;
        end
      end
      StBrake: begin
        if (tick) begin
          lft_d  = ramp(lft_cur, 12'sd0, BrkStp);
          rght_d = ramp(rght_cur, 12'sd0, BrkStp);
        end
        // Brake always runs to completion regardless of en/brake_req.
        if ((lft_q == '0) && (rght_q == '0)) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        lft_d   = '0;
        rght_d  = '0;
      end
    endcase
  end

  always_comb begin
    at_tgt_d = (state_q == StRun) && (lft_cur == cond_lft) && (rght_cur == cond_rght);
    moving_d = (lft_q != '0) || (rght_q != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      lft_q    <= '0;
      rght_q   <= '0;
      at_tgt_q <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lft_q    <= lft_d;
      rght_q   <= rght_d;
      at_tgt_q <= at_tgt_d;
      moving_q <= moving_d;
    end
  end

  assign bus.lft_spd  = lft_q;
  assign bus.rght_spd = rght_q;
  assign bus.at_tgt   = at_tgt_q;
  assign bus.moving   = moving_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_mtr_spd_sched.sv
// Directed scoreboard bench for mtr_spd_sched: expected speed steps are queued on stimulus
// and popped as the DUT speed outputs change.
module tb_mtr_spd_sched;

  logic clk;
  logic rst_n;
  int   vectors;
  int   errs;
  int   q_l[$];
  int   q_r[$];

  mtr_spd_sched_if bus ();

  mtr_spd_sched #(
    .UPD_DIV  (4),
    .RAMP_STEP(8),
    .BRK_STEP (32),
    .SPD_MAX  (1023),
    .DEADBAND (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lft_now();
    return int'($signed(bus.lft_spd));
  endfunction

  function automatic int rght_now();
    return int'($signed(bus.rght_spd));
  endfunction

  // Each change seen on a speed output pops and checks the next queued value.
  task automatic sb_run(input string tag, input int budget);
    int pl, pr, cl, cr, n;
    pl = lft_now();
    pr = rght_now();
    n  = 0;
    while ((q_l.size() > 0 || q_r.size() > 0) && n < budget) begin
      @(negedge clk);
      n++;
      cl = lft_now();
      cr = rght_now();
      if (cl != pl) begin
        if (q_l.size() > 0) chk({tag, "_lft"}, cl, q_l.pop_front());
        else chk({tag, "_lft_extra"}, cl, pl);
        pl = cl;
      end
      if (cr != pr) begin
        if (q_r.size() > 0) chk({tag, "_rght"}, cr, q_r.pop_front());
        else chk({tag, "_rght_extra"}, cr, pr);
        pr = cr;
      end
    end
    chk({tag, "_lft_left_over"}, q_l.size(), 0);
    chk({tag, "_rght_left_over"}, q_r.size(), 0);
    q_l.delete();
    q_r.delete();
  endtask

  task automatic chk_all(input string tag, input int l, input int r, input int at,
                         input int mv, input int st);
    chk({tag, "_lft"}, lft_now(), l);
    chk({tag, "_rght"}, rght_now(), r);
    chk({tag, "_at_tgt"}, int'(bus.at_tgt), at);
    chk({tag, "_moving"}, int'(bus.moving), mv);
    chk({tag, "_state"}, int'(bus.state), st);
  endtask

  initial begin
    int v;
    vectors       = 0;
    errs          = 0;
    rst_n         = 1'b1;
    bus.en        = 1'b0;
    bus.brake_req = 1'b0;
    bus.tgt_lft   = '0;
    bus.tgt_rght  = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_all("idle_no_en", 0, 0, 0, 0, 0);

    // Soft-start
    bus.tgt_lft  = 11'sd100;
    bus.tgt_rght = -11'sd50;
    bus.en       = 1'b1;
    for (int i = 1; i <= 12; i++) q_l.push_back(8 * i);
    q_l.push_back(100);
    for (int i = 1; i <= 6; i++) q_r.push_back(-8 * i);
    q_r.push_back(-50);
    sb_run("softstart", 80);
    chk("softstart_at_tgt_lag", int'(bus.at_tgt), 0);
    @(negedge clk);
    chk_all("softstart_done", 100, -50, 1, 1, 1);

    // Drop en and let the brake finish
    bus.en = 1'b0;
    for (int i = 0; i < 100 && bus.state != 2'b00; i++) @(negedge clk);
    chk("brake_to_idle", int'(bus.state), 0);

    // Brake mid-ramp
    bus.tgt_lft  = 11'sd100;
    bus.tgt_rght = -11'sd40;
    bus.en       = 1'b1;
    for (int i = 1; i <= 8; i++) q_l.push_back(8 * i);
    for (int i = 1; i <= 5; i++) q_r.push_back(-8 * i);
    sb_run("ramp64", 60);
    bus.brake_req = 1'b1;
    @(negedge clk);
    bus.brake_req = 1'b0;
    chk("brake_state", int'(bus.state), 2);
    chk("brake_at_tgt", int'(bus.at_tgt), 0);
    q_l.push_back(32);
    q_l.push_back(0);
    q_r.push_back(-8);
    q_r.push_back(0);
    sb_run("brake", 40);
    chk("brake_hold_state", int'(bus.state), 2);
    chk("brake_end_at_tgt", int'(bus.at_tgt), 0);
    @(negedge clk);
    chk_all("brake_idle", 0, 0, 0, 0, 0);
    bus.en = 1'b0;

    // Saturation and reversal
    bus.tgt_lft  = -11'sd1024;
    bus.tgt_rght = '0;
    bus.en       = 1'b1;
    for (int i = 1; i <= 127; i++) q_l.push_back(-8 * i);
    q_l.push_back(-1023);
    sb_run("sat", 600);
    @(negedge clk);
    chk_all("sat_done", -1023, 0, 1, 1, 1);
    bus.tgt_lft = 11'sd40;
    v = -1023;
    while (v != 40) begin
      v = (40 - v > 8) ? v + 8 : 40;
      q_l.push_back(v);
    end
    sb_run("up40", 600);
    bus.tgt_lft = -11'sd40;
    for (int i = 1; i <= 10; i++) q_l.push_back(40 - 8 * i);
    sb_run("reverse", 60);
    @(negedge clk);
    chk_all("reverse_done", -40, 0, 1, 1, 1);

    // en drop with immediate re-enable: brake still completes
    bus.tgt_lft = 11'sd96;
    for (v = -32; v <= 96; v += 8) q_l.push_back(v);
    sb_run("up96", 100);
    bus.en = 1'b0;
    @(negedge clk);
    bus.en = 1'b1;
    chk("reen_state_brake", int'(bus.state), 2);
    q_l.push_back(64);
    q_l.push_back(32);
    q_l.push_back(0);
    sb_run("reen_brake", 40);
    chk("reen_still_brake", int'(bus.state), 2);
    @(negedge clk);
    chk("reen_idle", int'(bus.state), 0);
    @(negedge clk);
    chk("reen_run", int'(bus.state), 1);

    // Asynchronous reset mid-ramp
    for (int i = 1; i <= 6; i++) q_l.push_back(8 * i);
    sb_run("ramp48", 40);
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 0);
    bus.tgt_lft  = 11'sd10;
    bus.tgt_rght = -11'sd15;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

`ifdef MTR_DEADBAND_EN
    repeat (20) @(negedge clk);
    chk_all("deadband", 0, 0, 1, 0, 1);
`else
    q_l.push_back(8);
    q_l.push_back(10);
    q_r.push_back(-8);
    q_r.push_back(-15);
    sb_run("small_tgt", 40);
    @(negedge clk);
    chk_all("small_tgt_done", 10, -15, 1, 1, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
